burst_mem_responder: RTL and testbench

//  Synthesizable responder (memory side) for the mp4 burst memory port: mem_read/mem_write/
//  mem_address/mem_wdata in; mem_rdata/mem_resp out. Serves 256-bit cache lines as four
//  64-bit beats after a fixed latency from an internal line-wide RAM. Used as an on-chip

---
 rtl/burst_mem_responder.sv | 147 ++++++++++++++
 tb/tb_burst_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the burst memory port: serves whole cache lines as
// BEATS consecutive beats after a fixed latency from an internal line-wide RAM.
module burst_mem_responder #(
    parameter int DATA_W    = 64,
    parameter int BEATS     = 4,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 4,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              err
);

    localparam int LINE_W = DATA_W * BEATS;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               is_read_q, is_read_d;
    logic               resp_q, resp_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               ram_we;
    logic               req_held;
    logic [IDX_W-1:0]   req_idx;
    logic [LINE_W-1:0]  rd_line;

    logic [LINE_W-1:0]  ram [DEPTH];

    // Offset and high address bits only select within a line or alias lines
    wire unused_addr = &{1'b0, mem_address[31:IDX_W+5], mem_address[4:0]};

    function automatic logic [DATA_W-1:0] beat_of(input logic [LINE_W-1:0] line,
                                                  input logic [BEAT_W-1:0] b);
        return line[DATA_W*b +: DATA_W];
    endfunction

    assign req_idx  = mem_address[5 +: IDX_W];
    assign req_held = is_read_q ? mem_read : mem_write;
    // With LATENCY=1 the first beat is fetched on the accept edge, before idx_q is loaded
    assign rd_line  = ram[(state_q == IDLE) ? req_idx : idx_q];

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        idx_d     = idx_q;
        is_read_d = is_read_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d     = req_idx;
                    is_read_d = mem_read;
                    beat_d    = '0;
                    if (mem_read && mem_write) err_d = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = BURST;
                        resp_d  = 1'b1;
                        rdata_d = mem_read ? beat_of(rd_line, '0) : '0;
                    end else begin
                        lat_d   = LAT_W'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_held) err_d = 1'b1;
                if (lat_q == LAT_W'(1)) begin
                    lat_d   = '0;
                    state_d = BURST;
                    beat_d  = '0;
                    resp_d  = 1'b1;
                    rdata_d = is_read_q ? beat_of(rd_line, '0) : '0;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            BURST: begin
                if (!req_held) err_d = 1'b1;
                ram_we = !is_read_q;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = DONE;
                    beat_d  = '0;
                    resp_d  = 1'b0;
                    rdata_d = '0;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    rdata_d = is_read_q ? beat_of(rd_line, beat_q + 1'b1) : '0;
                end
            end
            DONE: begin
                // A request still held from the last burst must drop before a new one
                if (!mem_read && !mem_write) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            beat_q    <= '0;
            idx_q     <= '0;
            is_read_q <= 1'b0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            beat_q    <= beat_d;
            idx_q     <= idx_d;
            is_read_q <= is_read_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // RAM is deliberately outside reset so contents survive an aborted burst
    always_ff @(posedge clk) begin
        if (ram_we) ram[idx_q][DATA_W*beat_q +: DATA_W] <= mem_wdata;
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: a line model feeds expected beats into a
// queue on each read request; captured beats are popped and compared per scenario.
module tb_burst_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_address = '0;
    logic [63:0] mem_wdata = '0;
    logic [63:0] mem_rdata;
    logic        mem_resp;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [63:0] model [256][4];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];
    logic [63:0] wbeats [4];
    int          first_cyc;
    int          extra_resp;
    bit          timed_out;

    burst_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[12:5]);
    endfunction

    task automatic push_expected(input logic [31:0] a);
        for (int k = 0; k < 4; k++) exp_q.push_back(model[idx_of(a)][k]);
    endtask

    task automatic commit_write(input logic [31:0] a);
        for (int k = 0; k < 4; k++) model[idx_of(a)][k] = wbeats[k];
    endtask

    task automatic new_wbeats();
        for (int k = 0; k < 4; k++) wbeats[k] = {$urandom, $urandom};
    endtask

    // Drives one request, captures every beat, then optionally keeps it held
    task automatic bus_burst(input logic [31:0] a, input bit rd, input bit wr,
                             input bit drop_early, input int hold_after);
        int cyc;
        int n;
        bit seen_end;
        got_q.delete();
        first_cyc = -1; extra_resp = 0; timed_out = 0;
        cyc = 0; n = 0; seen_end = 0;
        @(negedge clk);
        mem_address = a; mem_read = rd; mem_write = wr;
        mem_wdata = {$urandom, $urandom};
        @(posedge clk);
        while (!seen_end && !timed_out) begin
            @(negedge clk);
            if (drop_early && cyc == 0) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
            if (mem_resp) begin
                if (first_cyc < 0) first_cyc = cyc;
                got_q.push_back(mem_rdata);
                if (n < 4) mem_wdata = wbeats[n];
                n++;
            end else if (n > 0) begin
                seen_end = 1;
            end
            cyc++;
            if (cyc > 40) timed_out = 1;
        end
        repeat (hold_after) begin
            @(negedge clk);
            if (mem_resp) extra_resp++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (mem_resp !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp got=%b exp=0", mem_resp); end
        checks++; if (mem_rdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", mem_rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read(input logic [31:0] a, input string tag);
        logic [63:0] e, g;
        new_wbeats();
        bus_burst(a, 1'b0, 1'b1, 1'b0, 0);
        commit_write(a);
        checks++; if (timed_out || got_q.size() != 4) begin failures++; $display("[TB] FAIL %s_wr_beats got=%0d exp=4", tag, got_q.size()); end
        push_expected(a);
        bus_burst(a, 1'b1, 1'b0, 1'b0, 0);
        checks++; if (first_cyc != LAT - 1) begin failures++; $display("[TB] FAIL %s_latency got=%0d exp=%0d", tag, first_cyc, LAT - 1); end
        checks++; if (got_q.size() != 4) begin failures++; $display("[TB] FAIL %s_rd_beats got=%0d exp=4", tag, got_q.size()); end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++; if (g !== e) begin failures++; $display("[TB] FAIL %s_beat%0d got=%h exp=%h", tag, k, g, e); end
        end
    endtask

    task automatic test_alias();
        logic [63:0] e, g;
        new_wbeats();
        bus_burst(32'h0000_2000, 1'b0, 1'b1, 1'b0, 0);
        commit_write(32'h0000_2000);
        push_expected(32'h0000_001F);
        bus_burst(32'h0000_001F, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++; if (g !== e) begin failures++; $display("[TB] FAIL alias_beat%0d got=%h exp=%h", k, g, e); end
        end
    endtask

    task automatic test_both_high();
        logic [63:0] e, g;
        new_wbeats();
        push_expected(32'h0000_0040);
        bus_burst(32'h0000_0040, 1'b1, 1'b1, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++; if (g !== e) begin failures++; $display("[TB] FAIL both_beat%0d got=%h exp=%h", k, g, e); end
        end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL both_err got=%b exp=1", err); end
        push_expected(32'h0000_0040);
        bus_burst(32'h0000_0040, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++; if (g !== e) begin failures++; $display("[TB] FAIL both_unchanged%0d got=%h exp=%h", k, g, e); end
        end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL both_err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] e, g;
        int n;
        int cyc;
        new_wbeats();
        bus_burst(32'h0000_0060, 1'b0, 1'b1, 1'b0, 0);
        commit_write(32'h0000_0060);
        new_wbeats();
        n = 0; cyc = 0;
        @(negedge clk);
        mem_address = 32'h0000_0060; mem_write = 1'b1;
        while (n < 3 && cyc < 40) begin
            @(negedge clk);
            if (mem_resp) begin
                n++;
                if (n < 3) mem_wdata = wbeats[n-1];
            end
            cyc++;
        end
        checks++; if (n != 3) begin failures++; $display("[TB] FAIL rstmid_reach_beat2 got=%0d exp=3", n); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_resp !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_resp got=%b exp=0", mem_resp); end
        checks++; if (mem_rdata !== 64'h0) begin failures++; $display("[TB] FAIL rstmid_rdata got=%h exp=0", mem_rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_err got=%b exp=0", err); end
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model[idx_of(32'h0000_0060)][0] = wbeats[0];
        model[idx_of(32'h0000_0060)][1] = wbeats[1];
        push_expected(32'h0000_0060);
        bus_burst(32'h0000_0060, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++; if (g !== e) begin failures++; $display("[TB] FAIL rstmid_beat%0d got=%h exp=%h", k, g, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e, g;
        bus_burst(32'h0000_0020, 1'b1, 1'b0, 1'b0, 6);
        checks++; if (extra_resp != 0) begin failures++; $display("[TB] FAIL b2b_held_resp got=%0d exp=0", extra_resp); end
        push_expected(32'h0000_0020);
        bus_burst(32'h0000_0020, 1'b1, 1'b0, 1'b0, 0);
        checks++; if (first_cyc != LAT - 1) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", first_cyc, LAT - 1); end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++; if (g !== e) begin failures++; $display("[TB] FAIL b2b_beat%0d got=%h exp=%h", k, g, e); end
        end
    endtask

    task automatic test_deassert();
        logic [63:0] e, g;
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL drop_err_before got=%b exp=0", err); end
        push_expected(32'h0000_0080);
        bus_burst(32'h0000_0080, 1'b1, 1'b0, 1'b1, 0);
        checks++; if (got_q.size() != 4) begin failures++; $display("[TB] FAIL drop_beats got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++; if (g !== e) begin failures++; $display("[TB] FAIL drop_beat%0d got=%h exp=%h", k, g, e); end
        end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL drop_err got=%b exp=1", err); end
    endtask

    initial begin
        test_reset();
        test_write_read(32'h0000_0020, "line20");
        test_write_read(32'h0000_0080, "line80");
        test_write_read(32'h0000_0040, "line40");
        test_write_read(32'h0000_1FE0, "lastline");
        test_alias();
        test_both_high();
        test_reset_mid_write();
        test_back_to_back();
        test_deassert();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
